// File: rtl/c5_pkg.sv
// rtl/c5_pkg.sv - shared types, Q-format defaults and saturation bounds for the C5 MAC engine
//
// Holds the controller state encoding, the default word/fraction/accumulator
// widths, and helpers returning the signed saturation limits for a given
// output word width.
package c5_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        DRAIN,
        WRITE,
        DONE
    } c5_state_e;

    localparam int C5_DATA_WIDTH = 16;
    localparam int C5_FRAC_BITS  = 8;
    localparam int C5_ACC_WIDTH  = 40;

    // Largest representable signed value of a dw-bit word.
    function automatic longint c5_sat_hi(input int dw);
        return (64'sd1 <<< (dw - 1)) - 64'sd1;
    endfunction

    // Smallest representable signed value of a dw-bit word.
    function automatic longint c5_sat_lo(input int dw);
        return -(64'sd1 <<< (dw - 1));
    endfunction

endpackage

// File: rtl/c5_requant.sv
// rtl/c5_requant.sv - combinational requantiser: shift, saturate, optional ReLU
//
// Converts the wide accumulator back to the output Q format.
// Ports:
//   acc    in   ACC_WIDTH   signed accumulator (features*weights + bias, 2*FRAC_BITS fraction)
//   result out  DATA_WIDTH  signed output word (FRAC_BITS fraction)
// Macro C5_RELU_EN: when defined, negative saturated results are forced to 0.
module c5_requant
    import c5_pkg::*;
#(
    parameter int DATA_WIDTH = C5_DATA_WIDTH,
    parameter int FRAC_BITS  = C5_FRAC_BITS,
    parameter int ACC_WIDTH  = C5_ACC_WIDTH
) (
    input  logic [ACC_WIDTH-1:0]  acc,
    output logic [DATA_WIDTH-1:0] result
);

    localparam logic signed [ACC_WIDTH-1:0] SAT_HI = ACC_WIDTH'(c5_sat_hi(DATA_WIDTH));
    localparam logic signed [ACC_WIDTH-1:0] SAT_LO = ACC_WIDTH'(c5_sat_lo(DATA_WIDTH));

    logic signed [ACC_WIDTH-1:0] shifted;
    logic        [DATA_WIDTH-1:0] sat;

    // Arithmetic shift drops the extra fraction bits, rounding toward -inf.
    assign shifted = $signed(acc) >>> FRAC_BITS;

    always_comb begin
        if (shifted > SAT_HI) begin
            sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (shifted < SAT_LO) begin
            sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            sat = shifted[DATA_WIDTH-1:0];
        end
`ifdef C5_RELU_EN
        result = sat[DATA_WIDTH-1] ? '0 : sat;
`else
        result = sat;
`endif
    end

endmodule

// File: rtl/conv_layer5_mac.sv
// rtl/conv_layer5_mac.sv - C5 layer sequential multiply-accumulate engine
//
// Computes NUM_OUT neurons, each the dot product of the NUM_IN pooled L4
// features with its weight row plus a bias, and writes them to the L5 RAM.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             one-cycle request, honoured only in IDLE
//   L4_read_addr/dout pooled-feature read port (RD_LAT cycles latency)
//   w_read_addr/dout  weight ROM read port, address n*NUM_IN+i
//   b_read_addr/dout  bias ROM read port, address n
//   L5_write_addr/wea/din  output write port, active only in WRITE
//   busy              high while a layer is in progress
//   layer_done        one-cycle pulse after the last write
// Macro C5_RELU_EN: clamp negative outputs to zero (see c5_requant).
module conv_layer5_mac
    import c5_pkg::*;
#(
    parameter int DATA_WIDTH = C5_DATA_WIDTH,
    parameter int FRAC_BITS  = C5_FRAC_BITS,
    parameter int ACC_WIDTH  = C5_ACC_WIDTH,
    parameter int NUM_IN     = 400,
    parameter int NUM_OUT    = 120,
    parameter int RD_LAT     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [8:0]            L4_read_addr,
    input  logic [DATA_WIDTH-1:0] L4_dout,
    output logic [15:0]           w_read_addr,
    input  logic [DATA_WIDTH-1:0] w_dout,
    output logic [6:0]            b_read_addr,
    input  logic [DATA_WIDTH-1:0] b_dout,
    output logic [6:0]            L5_write_addr,
    output logic                  L5_wea,
    output logic [DATA_WIDTH-1:0] L5_din,
    output logic                  busy,
    output logic                  layer_done
);

    localparam int DC_W = $clog2(RD_LAT + 2);

    c5_state_e state, state_nxt;

    logic [8:0]      i_cnt;
    logic [6:0]      n_cnt;
    logic [15:0]     w_addr;
    logic [DC_W-1:0] drain_cnt;
    logic            last_i, last_n, drain_end;
    logic            issue, issue_first;

    logic [RD_LAT-1:0]              v_pipe, f_pipe;
    logic                           prod_v, prod_first;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [DATA_WIDTH-1:0]   bias_q;
    logic signed [ACC_WIDTH-1:0]    acc, prod_ext, bias_ext;
    logic [DATA_WIDTH-1:0]          result;

    assign last_i      = (i_cnt == 9'(NUM_IN - 1));
    assign last_n      = (n_cnt == 7'(NUM_OUT - 1));
    assign drain_end   = (drain_cnt == DC_W'(RD_LAT + 1));
    assign issue       = (state == ACCUM);
    assign issue_first = issue && (i_cnt == 9'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        L5_wea     = 1'b0;
        layer_done = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = ACCUM;
            end
            ACCUM: begin
                busy = 1'b1;
                if (last_i) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_end) state_nxt = WRITE;
            end
            WRITE: begin
                busy      = 1'b1;
                L5_wea    = 1'b1;
                state_nxt = last_n ? DONE : ACCUM;
            end
            DONE: begin
                busy       = 1'b1;
                layer_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Address counters. The weight address runs as a single counter across
    // neurons so no n*NUM_IN multiply is needed; addresses freeze on the last
    // issued index through DRAIN and WRITE.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_cnt     <= '0;
            n_cnt     <= '0;
            w_addr    <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    i_cnt     <= '0;
                    n_cnt     <= '0;
                    w_addr    <= '0;
                    drain_cnt <= '0;
                end
                ACCUM: begin
                    drain_cnt <= '0;
                    if (!last_i) begin
                        i_cnt  <= i_cnt + 9'd1;
                        w_addr <= w_addr + 16'd1;
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + DC_W'(1);
                end
                WRITE: begin
                    drain_cnt <= '0;
                    if (!last_n) begin
                        i_cnt  <= '0;
                        n_cnt  <= n_cnt + 7'd1;
                        w_addr <= w_addr + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign prod_ext = ACC_WIDTH'(prod);
    assign bias_ext = ACC_WIDTH'(bias_q) <<< FRAC_BITS;

    // Valid/first tags travel alongside the read latency so the product and
    // bias are captured exactly when the RAM/ROM data for an index arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_pipe     <= '0;
            f_pipe     <= '0;
            prod_v     <= 1'b0;
            prod_first <= 1'b0;
            prod       <= '0;
            bias_q     <= '0;
            acc        <= '0;
        end else begin
            v_pipe     <= RD_LAT'({v_pipe, issue});
            f_pipe     <= RD_LAT'({f_pipe, issue_first});
            prod_v     <= v_pipe[RD_LAT-1];
            prod_first <= f_pipe[RD_LAT-1];
            if (v_pipe[RD_LAT-1]) begin
                prod <= $signed(L4_dout) * $signed(w_dout);
            end
            if (f_pipe[RD_LAT-1]) begin
                bias_q <= $signed(b_dout);
            end
            if (prod_v) begin
                // The first product of a neuron replaces the old sum with the bias.
                acc <= prod_first ? (bias_ext + prod_ext) : (acc + prod_ext);
            end
        end
    end

    c5_requant #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_requant (
        .acc    (acc),
        .result (result)
    );

    assign L4_read_addr  = i_cnt;
    assign w_read_addr   = w_addr;
    assign b_read_addr   = n_cnt;
    assign L5_write_addr = (state == WRITE) ? n_cnt : '0;
    assign L5_din        = (state == WRITE) ? result : '0;

endmodule

// File: tb/tb_conv_layer5_mac.sv
// tb/tb_conv_layer5_mac.sv - self-checking bench for conv_layer5_mac (small and default configurations)
module tb_conv_layer5_mac;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Shared memory contents read by both DUT instances.
    logic [15:0] feat_m [0:511];
    logic [15:0] wt_m   [0:65535];
    logic [15:0] bias_m [0:127];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- small instance: NUM_IN=4, NUM_OUT=2 ----------------
    logic        s_rst = 1'b1, s_start = 1'b0, s_clr = 1'b0;
    logic [8:0]  s_l4_addr;
    logic [15:0] s_l4_dout, s_w_dout, s_b_dout, s_din;
    logic [15:0] s_w_addr;
    logic [6:0]  s_b_addr, s_wr_addr;
    logic        s_wea, s_busy, s_done;
    logic [15:0] s_l4_p, s_w_p, s_b_p;

    conv_layer5_mac #(.NUM_IN(4), .NUM_OUT(2), .RD_LAT(2)) dut (
        .clk(clk), .rst(s_rst), .start(s_start),
        .L4_read_addr(s_l4_addr), .L4_dout(s_l4_dout),
        .w_read_addr(s_w_addr), .w_dout(s_w_dout),
        .b_read_addr(s_b_addr), .b_dout(s_b_dout),
        .L5_write_addr(s_wr_addr), .L5_wea(s_wea), .L5_din(s_din),
        .busy(s_busy), .layer_done(s_done)
    );

    always @(posedge clk) begin
        s_l4_p <= feat_m[s_l4_addr]; s_l4_dout <= s_l4_p;
        s_w_p  <= wt_m[s_w_addr];    s_w_dout  <= s_w_p;
        s_b_p  <= bias_m[s_b_addr];  s_b_dout  <= s_b_p;
    end

    int          s_wr_cnt = 0, s_done_cnt = 0, s_start_cyc = 0, s_done_cyc = 0;
    logic [6:0]  s_wa_log [0:7];
    logic [15:0] s_wd_log [0:7];
    int          s_wc_log [0:7];

    always @(posedge clk) begin
        if (s_clr) begin
            s_wr_cnt   <= 0;
            s_done_cnt <= 0;
        end else begin
            if (s_start && !s_busy && !s_rst) s_start_cyc <= cyc;
            if (s_wea) begin
                if (s_wr_cnt < 8) begin
                    s_wa_log[s_wr_cnt] <= s_wr_addr;
                    s_wd_log[s_wr_cnt] <= s_din;
                    s_wc_log[s_wr_cnt] <= cyc;
                end
                s_wr_cnt <= s_wr_cnt + 1;
            end
            if (s_done) begin
                s_done_cnt <= s_done_cnt + 1;
                s_done_cyc <= cyc;
            end
        end
    end

    // ---------------- default-parameter instance ----------------
    logic        f_rst = 1'b1, f_start = 1'b0;
    logic [8:0]  f_l4_addr;
    logic [15:0] f_l4_dout, f_w_dout, f_b_dout, f_din;
    logic [15:0] f_w_addr;
    logic [6:0]  f_b_addr, f_wr_addr;
    logic        f_wea, f_busy, f_done;
    logic [15:0] f_l4_p, f_w_p, f_b_p;

    conv_layer5_mac dut_full (
        .clk(clk), .rst(f_rst), .start(f_start),
        .L4_read_addr(f_l4_addr), .L4_dout(f_l4_dout),
        .w_read_addr(f_w_addr), .w_dout(f_w_dout),
        .b_read_addr(f_b_addr), .b_dout(f_b_dout),
        .L5_write_addr(f_wr_addr), .L5_wea(f_wea), .L5_din(f_din),
        .busy(f_busy), .layer_done(f_done)
    );

    always @(posedge clk) begin
        f_l4_p <= feat_m[f_l4_addr]; f_l4_dout <= f_l4_p;
        f_w_p  <= wt_m[f_w_addr];    f_w_dout  <= f_w_p;
        f_b_p  <= bias_m[f_b_addr];  f_b_dout  <= f_b_p;
    end

    int          f_wr_cnt = 0, f_done_cnt = 0, f_start_cyc = 0, f_done_cyc = 0, f_first_wr = 0;
    int          f_w_bad = 0, f_w_steps = 0;
    logic [15:0] f_w_prev = 16'd0, f_w_max = 16'd0;
    logic [6:0]  f_wa_log [0:127];
    logic [15:0] f_wd_log [0:127];

    always @(posedge clk) begin
        if (f_start && !f_busy && !f_rst) f_start_cyc <= cyc;
        if (f_wea) begin
            if (f_wr_cnt < 128) begin
                f_wa_log[f_wr_cnt] <= f_wr_addr;
                f_wd_log[f_wr_cnt] <= f_din;
            end
            if (f_wr_cnt == 0) f_first_wr <= cyc;
            f_wr_cnt <= f_wr_cnt + 1;
        end
        if (f_done) begin
            f_done_cnt <= f_done_cnt + 1;
            f_done_cyc <= cyc;
        end
        f_w_prev <= f_w_addr;
        if (f_busy && f_w_addr != f_w_prev) begin
            if (f_w_addr == f_w_prev + 16'd1) f_w_steps <= f_w_steps + 1;
            else f_w_bad <= f_w_bad + 1;
        end
        if (f_w_addr > f_w_max) f_w_max <= f_w_addr;
    end

    // ---------------- reference model ----------------
    function automatic logic [15:0] golden(input int n);
        longint acc;
        acc = longint'($signed(bias_m[n])) <<< 8;
        for (int k = 0; k < 400; k++) begin
            acc += longint'($signed(feat_m[k])) * longint'($signed(wt_m[n*400 + k]));
        end
        acc = acc >>> 8;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
`ifdef C5_RELU_EN
        if (acc < 0) acc = 0;
`endif
        return 16'(acc);
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0] feat;
        logic [15:0] wt;
        logic [15:0] bias;
        logic [15:0] exp_lin;
        logic [15:0] exp_relu;
    } vec_t;

    vec_t vecs [0:7];

    task automatic load_vec(input vec_t v);
        for (int k = 0; k < 4; k++) feat_m[k] = v.feat;
        for (int k = 0; k < 8; k++) wt_m[k] = v.wt;
        for (int k = 0; k < 2; k++) bias_m[k] = v.bias;
    endtask

    function automatic logic [15:0] vec_exp(input vec_t v);
`ifdef C5_RELU_EN
        return v.exp_relu;
`else
        return v.exp_lin;
`endif
    endfunction

    task automatic clear_log();
        @(negedge clk); s_clr = 1'b1;
        @(negedge clk); s_clr = 1'b0;
    endtask

    task automatic wait_small_done(input string tag);
        int c;
        c = 0;
        while (s_done_cnt == 0 && c < 200) begin
            @(negedge clk);
            c++;
        end
        check({tag, " done seen"}, 32'(s_done_cnt != 0), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_small_run(input string tag, input logic [15:0] exp);
        check({tag, " write count"}, 32'(s_wr_cnt), 32'd2);
        check({tag, " addr0"}, 32'(s_wa_log[0]), 32'd0);
        check({tag, " addr1"}, 32'(s_wa_log[1]), 32'd1);
        check({tag, " data0"}, 32'(s_wd_log[0]), 32'(exp));
        check({tag, " data1"}, 32'(s_wd_log[1]), 32'(exp));
        check({tag, " first write latency"}, 32'(s_wc_log[0] - s_start_cyc), 32'd9);
        check({tag, " done latency"}, 32'(s_done_cyc - s_start_cyc), 32'd19);
        check({tag, " done pulses"}, 32'(s_done_cnt), 32'd1);
        check({tag, " idle after done"}, 32'(s_busy), 32'd0);
    endtask

    initial begin
        vecs[0] = '{16'h0100, 16'h0080, 16'h0100, 16'h0300, 16'h0300};
        vecs[1] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        vecs[2] = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h0000};
        vecs[3] = '{16'h0100, 16'hFF00, 16'h0000, 16'hFC00, 16'h0000};
        vecs[4] = '{16'h0200, 16'h0040, 16'hFF00, 16'h0100, 16'h0100};
        vecs[5] = '{16'h0100, 16'hFFC0, 16'h0080, 16'hFF80, 16'h0000};
        vecs[6] = '{16'h0001, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
        vecs[7] = '{16'h0001, 16'h0001, 16'h0000, 16'h0000, 16'h0000};

        for (int k = 0; k < 512; k++) feat_m[k] = 16'h0;
        for (int k = 0; k < 65536; k++) wt_m[k] = 16'h0;
        for (int k = 0; k < 128; k++) bias_m[k] = 16'h0;

        repeat (3) @(negedge clk);
        s_rst = 1'b0;
        f_rst = 1'b0;
        @(negedge clk);
        check("reset busy", 32'(s_busy), 32'd0);
        check("reset wea", 32'(s_wea), 32'd0);
        check("reset done", 32'(s_done), 32'd0);
        check("reset addrs", 32'({s_l4_addr, s_w_addr, s_b_addr, s_wr_addr}), 32'd0);
        check("reset din", 32'(s_din), 32'd0);

        // Table-driven single-layer runs.
        for (int v = 0; v < 8; v++) begin
            load_vec(vecs[v]);
            clear_log();
            @(negedge clk); s_start = 1'b1;
            @(negedge clk); s_start = 1'b0;
            wait_small_done($sformatf("vec%0d", v));
            check_small_run($sformatf("vec%0d", v), vec_exp(vecs[v]));
        end

        // Second start three cycles into the run is ignored.
        load_vec(vecs[0]);
        clear_log();
        @(negedge clk); s_start = 1'b1;
        @(negedge clk); s_start = 1'b0;
        repeat (2) @(negedge clk);
        s_start = 1'b1;
        @(negedge clk); s_start = 1'b0;
        wait_small_done("busy start");
        check_small_run("busy start", vec_exp(vecs[0]));

        // Reset while neuron 1 accumulates, with start asserted alongside rst.
        clear_log();
        @(negedge clk); s_start = 1'b1;
        @(negedge clk); s_start = 1'b0;
        repeat (10) @(negedge clk);
        check("midrst neuron0 written", 32'(s_wr_cnt), 32'd1);
        check("midrst in accum", 32'(s_busy), 32'd1);
        s_rst = 1'b1;
        s_start = 1'b1;
        @(negedge clk);
        check("midrst busy", 32'(s_busy), 32'd0);
        check("midrst wea", 32'(s_wea), 32'd0);
        check("midrst addrs", 32'({s_l4_addr, s_w_addr, s_b_addr, s_wr_addr}), 32'd0);
        @(negedge clk);
        s_rst = 1'b0;
        s_start = 1'b0;
        @(negedge clk);
        check("start with rst ignored", 32'(s_busy), 32'd0);
        clear_log();
        @(negedge clk); s_start = 1'b1;
        @(negedge clk); s_start = 1'b0;
        wait_small_done("after rst");
        check_small_run("after rst", vec_exp(vecs[0]));

        // Default parameters with random data against the reference model.
        begin
            logic [15:0] gold [0:119];
            int c;
            for (int k = 0; k < 400; k++) feat_m[k] = 16'($urandom_range(0, 1023)) - 16'd512;
            for (int k = 0; k < 48000; k++) wt_m[k] = 16'($urandom_range(0, 255)) - 16'd128;
            for (int k = 0; k < 120; k++) bias_m[k] = 16'($urandom_range(0, 65535));
            for (int k = 0; k < 120; k++) gold[k] = golden(k);
            @(negedge clk); f_start = 1'b1;
            @(negedge clk); f_start = 1'b0;
            c = 0;
            while (f_done_cnt == 0 && c < 50000) begin
                @(negedge clk);
                c++;
            end
            check("full done seen", 32'(f_done_cnt != 0), 32'd1);
            repeat (4) @(negedge clk);
            check("full write count", 32'(f_wr_cnt), 32'd120);
            for (int k = 0; k < 120; k++) begin
                check($sformatf("full addr%0d", k), 32'(f_wa_log[k]), 32'(k));
                check($sformatf("full data%0d", k), 32'(f_wd_log[k]), 32'(gold[k]));
            end
            check("full first write latency", 32'(f_first_wr - f_start_cyc), 32'd405);
            check("full done latency", 32'(f_done_cyc - f_start_cyc), 32'd48601);
            check("full done pulses", 32'(f_done_cnt), 32'd1);
            check("full w addr jumps", 32'(f_w_bad), 32'd0);
            check("full w addr steps", 32'(f_w_steps), 32'd47999);
            check("full w addr max", 32'(f_w_max), 32'd47999);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
